// File: rtl/gate_logic_sequencer.sv
// -----------------------------------------------------------------------------
// gate_logic_sequencer
//
// Purpose:
//   Self-checking sequencer that sits beside a gate_logic unit
//   (and/or/xor/xnor/nand/notb). On start it sweeps the unit's (a,b) inputs
//   through 00, 01, 10, 11, LOOPS times. Each vector is held for SETTLE_CYCLES
//   cycles and then sampled for one CHECK cycle, where the six gate outputs are
//   compared against the truth table. Mismatches accumulate into a sticky
//   per-gate mask and a saturating count; a one-cycle done pulse ends the run
//   and pass reports whether the mask stayed clear.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   LOOPS          full 4-vector sweeps per run (>= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset (priority over start)
//   start      in   level; only looked at in IDLE
//   gl_a/gl_b  out  registered stimulus to gate_logic (= vec_idx[1]/vec_idx[0])
//   gl_out     in   {notb,nand,xnor,xor,or,and}, bit0 = and
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse at end of run
//   pass       out  last run finished with err_mask == 0
//   err_mask   out  sticky per-gate mismatch flags (gl_out bit order)
//   err_count  out  total mismatching gate samples, saturating at 255
//   vec_idx    out  current vector index
// -----------------------------------------------------------------------------
module gate_logic_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gl_a,
  output logic       gl_b,
  input  logic [5:0] gl_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_mask,
  output logic [7:0] err_count,
  output logic [1:0] vec_idx
);

  // Counter widths are kept at least one bit wide so SETTLE_CYCLES=1 and
  // LOOPS=1 still produce legal vectors.
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [1:0]        vec_idx_q, vec_idx_d;
  logic              gl_a_q, gl_a_d;
  logic              gl_b_q, gl_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [5:0]        err_mask_q, err_mask_d;
  logic [7:0]        err_count_q, err_count_d;

  // ---------------------------------------------------------------------------
  // Compare datapath: expected gate outputs for the vector currently applied.
  // gl_a_q/gl_b_q are what gate_logic is actually seeing this cycle.
  // ---------------------------------------------------------------------------
  logic [5:0] exp_out;
  logic [5:0] mism;
  logic [3:0] mism_pop;
  logic [8:0] count_sum;
  logic [7:0] count_sat;
  logic       settle_last;
  logic       run_last;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    exp_out = {~gl_b_q, ~(gl_a_q & gl_b_q), ~(gl_a_q ^ gl_b_q),
               gl_a_q ^ gl_b_q, gl_a_q | gl_b_q, gl_a_q & gl_b_q};
    mism    = gl_out ^ exp_out;

    mism_pop = '0;
    for (int i = 0; i < 6; i++) begin
      mism_pop = mism_pop + {3'b000, mism[i]};
    end

    count_sum = {1'b0, err_count_q} + {5'b00000, mism_pop};
    count_sat = count_sum[8] ? 8'hff : count_sum[7:0];

    settle_last = (settle_cnt_q == SETTLE_LAST);
    run_last    = (vec_idx_q == 2'd3) && (loop_q == LOOP_LAST);
  end

  // ---------------------------------------------------------------------------
  // State register plus all datapath/output flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      loop_q       <= '0;
      vec_idx_q    <= '0;
      gl_a_q       <= 1'b0;
      gl_b_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      loop_q       <= loop_d;
      vec_idx_q    <= vec_idx_d;
      gl_a_q       <= gl_a_d;
      gl_b_q       <= gl_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      err_count_q  <= err_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)       state_d = S_SETTLE;
      S_SETTLE: if (settle_last) state_d = S_CHECK;
      S_CHECK:  state_d = run_last ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. Everything holds by default; done is a
  // pulse so it defaults low.
  // ---------------------------------------------------------------------------
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    loop_d       = loop_q;
    vec_idx_d    = vec_idx_q;
    gl_a_d       = gl_a_q;
    gl_b_d       = gl_b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    err_count_d  = err_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_mask_d   = '0;
          err_count_d  = '0;
          pass_d       = 1'b0;
          vec_idx_d    = 2'd0;
          loop_d       = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
          gl_a_d       = 1'b0;
          gl_b_d       = 1'b0;
        end
      end

      S_SETTLE: begin
        settle_cnt_d = settle_last ? '0 : settle_cnt_q + SET_W'(1);
      end

      S_CHECK: begin
        err_mask_d  = err_mask_q | mism;
        err_count_d = count_sat;
        if (run_last) begin
          // pass must include the mismatches found in this final CHECK,
          // hence it looks at the updated mask rather than err_mask_q.
          done_d    = 1'b1;
          busy_d    = 1'b0;
          pass_d    = (err_mask_d == 6'd0);
          vec_idx_d = 2'd0;
          loop_d    = '0;
          gl_a_d    = 1'b0;
          gl_b_d    = 1'b0;
        end else begin
          // vec_idx wraps 3->0 naturally; the wrap is what advances the loop.
          vec_idx_d = vec_idx_q + 2'd1;
          if (vec_idx_q == 2'd3) begin
            loop_d = loop_q + LOOP_W'(1);
          end
          gl_a_d = vec_idx_d[1];
          gl_b_d = vec_idx_d[0];
        end
      end

      S_DONE: begin
        // One-cycle report state; results simply hold.
      end

      default: begin
      end
    endcase
  end

  assign gl_a      = gl_a_q;
  assign gl_b      = gl_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate_logic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_logic_sequencer
//
// Three sequencer instances share clk/rst:
//   inst 0: SETTLE_CYCLES=2, LOOPS=1  (defaults)
//   inst 1: SETTLE_CYCLES=2, LOOPS=2
//   inst 2: SETTLE_CYCLES=1, LOOPS=12 (reaches err_count saturation)
// Each has its own gate_logic model with injectable faults: an invert mask and
// a stuck-at-0 mask per gate output.
// -----------------------------------------------------------------------------
module tb_gate_logic_sequencer;

  logic       clk;
  logic       rst;
  logic       start_s  [3];
  logic [5:0] inv_s    [3];
  logic [5:0] sa0_s    [3];
  logic       gla      [3];
  logic       glb      [3];
  logic [5:0] glo      [3];
  logic       busy_o   [3];
  logic       done_o   [3];
  logic       pass_o   [3];
  logic [5:0] mask_o   [3];
  logic [7:0] cnt_o    [3];
  logic [1:0] vidx_o   [3];

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_logic_sequencer #(.SETTLE_CYCLES(2), .LOOPS(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .gl_a(gla[0]), .gl_b(glb[0]),
    .gl_out(glo[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .err_mask(mask_o[0]), .err_count(cnt_o[0]), .vec_idx(vidx_o[0]));

  gate_logic_sequencer #(.SETTLE_CYCLES(2), .LOOPS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .gl_a(gla[1]), .gl_b(glb[1]),
    .gl_out(glo[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .err_mask(mask_o[1]), .err_count(cnt_o[1]), .vec_idx(vidx_o[1]));

  gate_logic_sequencer #(.SETTLE_CYCLES(1), .LOOPS(12)) dut2 (
    .clk(clk), .rst(rst), .start(start_s[2]), .gl_a(gla[2]), .gl_b(glb[2]),
    .gl_out(glo[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]),
    .err_mask(mask_o[2]), .err_count(cnt_o[2]), .vec_idx(vidx_o[2]));

  // gate_logic model (healthy function with fault injection on top).
  function automatic logic [5:0] gate_fn(input logic a, input logic b);
    return {~b, ~(a & b), ~(a ^ b), a ^ b, a | b, a & b};
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      glo[i] = (gate_fn(gla[i], glb[i]) ^ inv_s[i]) & ~sa0_s[i];
    end
  end

  function automatic int settle_of(input int inst);
    case (inst)
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int loops_of(input int inst);
    case (inst)
      1:       return 2;
      2:       return 12;
      default: return 1;
    endcase
  endfunction

  // Truth-table column of gate g, bit v = output for (a,b) = v.
  function automatic logic [3:0] tt_col(input int g);
    case (g)
      0:       return 4'b1000; // and
      1:       return 4'b1110; // or
      2:       return 4'b0110; // xor
      3:       return 4'b1001; // xnor
      4:       return 4'b0111; // nand
      default: return 4'b0101; // notb
    endcase
  endfunction

  // Reference model: counts mismatching samples over one sweep, scales by the
  // sweep count and saturates.
  task automatic model(input int inst, input logic [5:0] inv, input logic [5:0] sa0,
                       output logic [5:0] m, output logic [7:0] c, output logic p);
    int per_sweep;
    int total;
    logic [3:0] col;
    logic good;
    logic obs;
    per_sweep = 0;
    m = '0;
    for (int g = 0; g < 6; g++) begin
      col = tt_col(g);
      for (int v = 0; v < 4; v++) begin
        good = col[v];
        obs  = (good ^ inv[g]) & ~sa0[g];
        if (obs != good) begin
          per_sweep++;
          m[g] = 1'b1;
        end
      end
    end
    total = per_sweep * loops_of(inst);
    c = (total > 255) ? 8'hff : 8'(total);
    p = (m == 6'd0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full run on an instance. mode 0: plain start pulse. mode 1: start is
  // re-asserted mid-run and during DONE (both must be ignored). mode 2: start
  // held high throughout, so a second run begins two cycles after done; that
  // second run is then aborted with rst.
  task automatic run_check(input string tag, input int inst,
                           input logic [5:0] inv, input logic [5:0] sa0,
                           input logic [5:0] e_mask, input logic [7:0] e_cnt,
                           input logic e_pass, input int mode);
    int s1;
    int n;
    int v;
    s1 = settle_of(inst) + 1;
    n  = 4 * loops_of(inst) * s1;
    inv_s[inst] = inv;
    sa0_s[inst] = sa0;
    @(negedge clk);
    start_s[inst] = 1'b1;
    @(negedge clk);                       // just after the accepting edge (edge 0)
    if (mode != 2) start_s[inst] = 1'b0;
    check({tag, " cleared mask"},  mask_o[inst], 0);
    check({tag, " cleared count"}, cnt_o[inst],  0);
    check({tag, " cleared pass"},  pass_o[inst], 0);
    for (int j = 0; j < n; j++) begin
      v = (j / s1) % 4;
      check($sformatf("%s gl_a j%0d", tag, j), gla[inst], (v >> 1) & 1);
      check($sformatf("%s gl_b j%0d", tag, j), glb[inst], v & 1);
      check($sformatf("%s vidx j%0d", tag, j), vidx_o[inst], v);
      check($sformatf("%s busy j%0d", tag, j), busy_o[inst], 1);
      check($sformatf("%s done j%0d", tag, j), done_o[inst], 0);
      if (mode == 1 && j == 3) start_s[inst] = 1'b1;
      if (mode == 1 && j == 4) start_s[inst] = 1'b0;
      @(negedge clk);
    end
    // Just after edge n: the done cycle.
    check({tag, " done pulse"}, done_o[inst], 1);
    check({tag, " done busy"},  busy_o[inst], 0);
    check({tag, " done gl"},    {gla[inst], glb[inst]}, 0);
    check({tag, " err_mask"},   mask_o[inst], e_mask);
    check({tag, " err_count"},  cnt_o[inst],  e_cnt);
    check({tag, " pass"},       pass_o[inst], e_pass);
    if (mode == 1) start_s[inst] = 1'b1;
    @(negedge clk);
    check({tag, " post done"},  done_o[inst], 0);
    check({tag, " post busy"},  busy_o[inst], 0);
    check({tag, " hold mask"},  mask_o[inst], e_mask);
    check({tag, " hold count"}, cnt_o[inst],  e_cnt);
    check({tag, " hold pass"},  pass_o[inst], e_pass);
    if (mode == 1) start_s[inst] = 1'b0;
    if (mode == 2) begin
      @(negedge clk);
      check({tag, " restart busy"},  busy_o[inst], 1);
      check({tag, " restart mask"},  mask_o[inst], 0);
      check({tag, " restart count"}, cnt_o[inst],  0);
      check({tag, " restart pass"},  pass_o[inst], 0);
      start_s[inst] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check({tag, " abort busy"}, busy_o[inst], 0);
      check({tag, " abort done"}, done_o[inst], 0);
      rst = 1'b0;
    end
    inv_s[inst] = '0;
    sa0_s[inst] = '0;
  endtask

  typedef struct {
    int         inst;
    logic [5:0] inv;
    logic [5:0] sa0;
    logic [5:0] mask;
    logic [7:0] cnt;
    logic       pass;
    int         mode;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [5:0] m_exp;
    logic [7:0] c_exp;
    logic       p_exp;
    logic       seen_done;
    logic       seen_busy;
    int         ri;
    logic [5:0] rinv;
    logic [5:0] rsa0;

    tbl[0] = '{0, 6'h00, 6'h00, 6'h00, 8'd0,   1'b1, 0}; // healthy, defaults
    tbl[1] = '{0, 6'h00, 6'h04, 6'h04, 8'd2,   1'b0, 0}; // xor stuck-at-0
    tbl[2] = '{0, 6'h00, 6'h00, 6'h00, 8'd0,   1'b1, 1}; // start re-pulsed
    tbl[3] = '{1, 6'h20, 6'h00, 6'h20, 8'd8,   1'b0, 0}; // LOOPS=2, notb inverted
    tbl[4] = '{2, 6'h3f, 6'h00, 6'h3f, 8'd255, 1'b0, 0}; // 288 errors saturate
    tbl[5] = '{2, 6'h00, 6'h00, 6'h00, 8'd0,   1'b1, 0}; // cleared after saturation
    tbl[6] = '{0, 6'h01, 6'h02, 6'h03, 8'd7,   1'b0, 0}; // and inverted + or sa0
    tbl[7] = '{0, 6'h00, 6'h00, 6'h00, 8'd0,   1'b1, 2}; // start held high

    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b1;   // asserted together with rst: must not start a run
      inv_s[i]   = '0;
      sa0_s[i]   = '0;
    end
    rst = 1'b1;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst busy%0d", i), busy_o[i], 0);
      check($sformatf("rst outs%0d", i),
            {gla[i], glb[i], done_o[i], pass_o[i], mask_o[i], cnt_o[i], vidx_o[i]}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
    @(negedge clk);
    check("post rst idle busy", busy_o[0], 0);
    check("post rst idle gl",   {gla[0], glb[0]}, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].inst, tbl[i].inv, tbl[i].sa0,
                tbl[i].mask, tbl[i].cnt, tbl[i].pass, tbl[i].mode);
    end

    // rst while settling vector 2: immediate return to reset values, no done.
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int j = 0; j < 6; j++) @(negedge clk);
    check("abort vidx before rst", vidx_o[0], 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy",  busy_o[0], 0);
    check("abort gl",    {gla[0], glb[0]}, 0);
    check("abort vidx",  vidx_o[0], 0);
    check("abort done",  done_o[0], 0);
    rst = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      seen_done |= done_o[0];
      seen_busy |= busy_o[0];
    end
    check("abort no done later", seen_done, 0);
    check("abort stays idle",    seen_busy, 0);

    // Randomized fault patterns checked against the reference model.
    for (int r = 0; r < 12; r++) begin
      ri   = $urandom_range(0, 2);
      rinv = 6'($urandom & $urandom);
      rsa0 = 6'($urandom & $urandom & $urandom);
      model(ri, rinv, rsa0, m_exp, c_exp, p_exp);
      run_check($sformatf("rnd%0d", r), ri, rinv, rsa0, m_exp, c_exp, p_exp, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
